// File: rtl/wb_master_seq_if.sv
// Command/response port plus Wishbone classic initiator bus for wb_master_seq.
// master = the sequencer side, slave = the command source and bus target side.
interface wb_master_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [3:0]        cmd_sel;
    logic [ADDR_W-1:0] cmd_adr;
    logic [DATA_W-1:0] cmd_dat;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp_err;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic              wbm_ack_i;
    logic [DATA_W-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_we,
        input  cmd_sel,
        input  cmd_adr,
        input  cmd_dat,
        output rsp_valid,
        input  rsp_ready,
        output rsp_dat,
        output rsp_err,
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_sel_o,
        output wbm_adr_o,
        output wbm_dat_o,
        input  wbm_ack_i,
        input  wbm_dat_i
    );

    modport slave (
        output cmd_valid,
        input  cmd_ready,
        output cmd_we,
        output cmd_sel,
        output cmd_adr,
        output cmd_dat,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_dat,
        input  rsp_err,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_sel_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        output wbm_ack_i,
        output wbm_dat_i
    );
endinterface

// File: rtl/wb_master_seq.sv
// Single-outstanding Wishbone classic initiator driven by a valid/ready command port.
// Define WBM_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES cycles without ack.
module wb_master_seq #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_master_seq_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_master_seq: DATA_W must be 32, TIMEOUT_CYCLES >= 1");
    end

    state_t            state;
    state_t            state_n;
    logic              cyc;
    logic              cyc_n;
    logic              we;
    logic              we_n;
    logic [3:0]        sel;
    logic [3:0]        sel_n;
    logic [ADDR_W-1:0] adr;
    logic [ADDR_W-1:0] adr_n;
    logic [DATA_W-1:0] dat;
    logic [DATA_W-1:0] dat_n;
    logic              rsp_valid;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_dat;
    logic [DATA_W-1:0] rsp_dat_n;
    logic              cmd_ready;
    logic              accept;
    logic              cmd_write;
    logic              done;

    // sel == 0 can never write on the target, so issue it as a read
    assign cmd_write = bus.cmd_we & (|bus.cmd_sel);
    assign cmd_ready = (state == IDLE) & ~wb_rst_i;
    assign accept    = bus.cmd_valid & cmd_ready;

`ifdef WBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             expired;
    logic             rsp_err;
    logic             rsp_err_n;

    assign cnt_inc = cnt + 1'b1;
    assign expired = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_n     = state;
        cyc_n       = cyc;
        we_n        = we;
        sel_n       = sel;
        adr_n       = adr;
        dat_n       = dat;
        rsp_valid_n = rsp_valid;
        rsp_dat_n   = rsp_dat;
        done        = 1'b0;
`ifdef WBM_TIMEOUT_EN
        cnt_n       = cnt;
        rsp_err_n   = rsp_err;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = BUS;
                    cyc_n   = 1'b1;
                    we_n    = cmd_write;
                    sel_n   = bus.cmd_sel;
                    adr_n   = bus.cmd_adr;
                    dat_n   = cmd_write ? bus.cmd_dat : '0;
`ifdef WBM_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            BUS: begin
                if (bus.wbm_ack_i) begin
                    done      = 1'b1;
                    rsp_dat_n = we ? '0 : bus.wbm_dat_i;
                end
`ifdef WBM_TIMEOUT_EN
                // ack on the limit edge still completes normally
                if (bus.wbm_ack_i) begin
                    rsp_err_n = 1'b0;
                end else if (expired) begin
                    done      = 1'b1;
                    rsp_dat_n = '0;
                    rsp_err_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
`endif
                if (done) begin
                    state_n     = RESP;
                    cyc_n       = 1'b0;
                    we_n        = 1'b0;
                    sel_n       = '0;
                    adr_n       = '0;
                    dat_n       = '0;
                    rsp_valid_n = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: begin
                state_n     = IDLE;
                cyc_n       = 1'b0;
                we_n        = 1'b0;
                sel_n       = '0;
                adr_n       = '0;
                dat_n       = '0;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cyc       <= 1'b0;
            we        <= 1'b0;
            sel       <= '0;
            adr       <= '0;
            dat       <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            we        <= we_n;
            sel       <= sel_n;
            adr       <= adr_n;
            dat       <= dat_n;
            rsp_valid <= rsp_valid_n;
            rsp_dat   <= rsp_dat_n;
        end
    end

`ifdef WBM_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt     <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            rsp_err <= rsp_err_n;
        end
    end

    assign bus.rsp_err = rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_dat   = rsp_dat;
    assign bus.wbm_cyc_o = cyc;
    assign bus.wbm_stb_o = cyc;
    assign bus.wbm_we_o  = we;
    assign bus.wbm_sel_o = sel;
    assign bus.wbm_adr_o = adr;
    assign bus.wbm_dat_o = dat;
endmodule
